// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: state encoding, data width,
// FIFO depth and a counter-width helper.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Output buffer for the UART receiver: shift-register FIFO whose head entry
// is always slot 0, so the head data comes straight from a register.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [UART_DATA_W-1:0] push_data,
    input  logic                   pop,
    output logic [UART_DATA_W-1:0] pop_data,
    output logic                   full,
    output logic                   empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [UART_DATA_W-1:0] mem_r   [DEPTH];
    logic [UART_DATA_W-1:0] shift_s [DEPTH];
    logic [UART_DATA_W-1:0] mem_n_s [DEPTH];
    logic [CNT_W-1:0]       count_r;
    logic [CNT_W-1:0]       count_after_s;
    logic [CNT_W-1:0]       count_n_s;
    logic                   pop_ok_s;
    logic                   push_ok_s;
    logic                   full_r;
    logic                   empty_r;

    // Next-state: shift out the head on pop, then drop a push into the first free slot.
    always_comb begin
        pop_ok_s      = pop && !empty_r;
        count_after_s = count_r - CNT_W'(pop_ok_s);
        push_ok_s     = push && (count_after_s < CNT_W'(DEPTH));
        for (int i = 0; i < DEPTH - 1; i++) begin
            shift_s[i] = pop_ok_s ? mem_r[i + 1] : mem_r[i];
        end
        shift_s[DEPTH - 1] = mem_r[DEPTH - 1];
        for (int i = 0; i < DEPTH; i++) begin
            mem_n_s[i] = (push_ok_s && (count_after_s == CNT_W'(i))) ? push_data : shift_s[i];
        end
        count_n_s = count_after_s + CNT_W'(push_ok_s);
    end

    // Storage, occupancy and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {UART_DATA_W{1'b0}};
            end
            count_r <= {CNT_W{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            mem_r   <= mem_n_s;
            count_r <= count_n_s;
            full_r  <= (count_n_s == CNT_W'(DEPTH));
            empty_r <= (count_n_s == {CNT_W{1'b0}});
        end
    end

    assign pop_data = mem_r[0];
    assign full     = full_r;
    assign empty    = empty_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with synchronizer, mid-bit sampling FSM and output buffer.
// Define UART_RX_FIFO_EN for a 4-entry FIFO; otherwise a single holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_pin,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   frame_err,
    output logic                   overrun
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int HALF  = (CLKS_PER_BIT - 32'sd1) / 32'sd2;
    localparam bit SKIP_START = (HALF == 32'sd0);
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 32'sd1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'((HALF > 32'sd0) ? HALF - 32'sd1 : 32'sd0);

`ifdef UART_RX_FIFO_EN
    localparam int BUF_DEPTH = UART_FIFO_DEPTH;
`else
    localparam int BUF_DEPTH = 1;
`endif

    logic                   sync1_r;
    logic                   rx_s;
    rx_state_e              state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [2:0]             bit_idx_r;
    logic [UART_DATA_W-1:0] shift_r;
    logic                   push_r;
    logic                   frame_err_r;
    logic                   overrun_r;
    logic                   pop_s;
    logic                   full_s;
    logic                   empty_s;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_r <= rx_pin;
            rx_s    <= sync1_r;
        end
    end

    // Frame decoder; push and frame_err are single-cycle registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            bit_idx_r   <= 3'd0;
            shift_r     <= {UART_DATA_W{1'b0}};
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!rx_s) begin
                        if (SKIP_START) begin
                            state_r   <= ST_DATA;
                            cnt_r     <= BIT_RELOAD;
                            bit_idx_r <= 3'd0;
                        end else begin
                            state_r <= ST_START;
                            cnt_r   <= HALF_RELOAD;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        if (!rx_s) begin
                            state_r   <= ST_DATA;
                            cnt_r     <= BIT_RELOAD;
                            bit_idx_r <= 3'd0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        shift_r[bit_idx_r] <= rx_s;
                        cnt_r              <= BIT_RELOAD;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        if (rx_s) begin
                            push_r  <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= ST_WAIT_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign pop_s = rx_valid && rx_ready;

    // A push into a full buffer with no simultaneous pop loses the new byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= push_r && full_s && !pop_s;
        end
    end

    uart_rx_fifo #(
        .DEPTH(BUF_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_r),
        .push_data(shift_r),
        .pop      (pop_s),
        .pop_data (rx_data),
        .full     (full_s),
        .empty    (empty_s)
    );

    assign rx_valid  = !empty_s;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a fast (1 clk/bit) and a slow (16 clk/bit) receiver driven
// by a behavioural serial transmitter and checked against expected byte queues.
module tb_uart_rx;

`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx1 = 1'b1, ready1 = 1'b1, valid1, fe1, ov1;
    logic       rx16 = 1'b1, ready16 = 1'b1, valid16, fe16, ov16;
    logic [7:0] data1, data16;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int fe_cnt1 = 0, ov_cnt1 = 0, fe_cnt16 = 0, ov_cnt16 = 0;
    bit rand_rdy1 = 1'b0;
    logic hold1 = 1'b0, hold16 = 1'b0;
    logic [7:0] hdata1 = 8'h00, hdata16 = 8'h00;
    logic [7:0] got1[$], exp1[$], got16[$], exp16[$];

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .reset(reset), .rx_pin(rx1), .rx_data(data1), .rx_valid(valid1),
        .rx_ready(ready1), .frame_err(fe1), .overrun(ov1)
    );

    uart_rx #(.CLKS_PER_BIT(16)) dut16 (
        .clk(clk), .reset(reset), .rx_pin(rx16), .rx_data(data16), .rx_valid(valid16),
        .rx_ready(ready16), .frame_err(fe16), .overrun(ov16)
    );

    // One clock: observe at the falling edge, then return just after the rising edge.
    task automatic step();
        @(negedge clk);
        if (!reset) begin
            if (valid1 && ready1) got1.push_back(data1);
            if (valid16 && ready16) got16.push_back(data16);
            if (fe1) fe_cnt1++;
            if (ov1) ov_cnt1++;
            if (fe16) fe_cnt16++;
            if (ov16) ov_cnt16++;
            if (hold1) begin
                n_vec++;
                if (!valid1 || data1 !== hdata1) begin
                    n_err++;
                    $display("FAIL hold1: valid=%0b data=%h, required valid=1 data=%h", valid1, data1, hdata1);
                end
            end
            if (hold16) begin
                n_vec++;
                if (!valid16 || data16 !== hdata16) begin
                    n_err++;
                    $display("FAIL hold16: valid=%0b data=%h, required valid=1 data=%h", valid16, data16, hdata16);
                end
            end
            hold1 = valid1 && !ready1;
            hdata1 = data1;
            hold16 = valid16 && !ready16;
            hdata16 = data16;
        end else begin
            hold1 = 1'b0;
            hold16 = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rand_rdy1) ready1 = ($urandom_range(0, 1) == 1) || (cyc % 4 == 0);
    endtask

    task automatic drive_line(input int which, input logic v, input int n);
        if (which == 0) rx1 = v;
        else rx16 = v;
        repeat (n) step();
    endtask

    // Serial transmitter: start, 8 data bits LSB first, stop, then idle gap.
    task automatic send_frame(input int which, input logic [7:0] b, input logic stop_bit, input int gap);
        int cpb;
        cpb = (which == 0) ? 1 : 16;
        drive_line(which, 1'b0, cpb);
        for (int i = 0; i < 8; i++) drive_line(which, b[i], cpb);
        drive_line(which, stop_bit, cpb);
        drive_line(which, 1'b1, gap * cpb);
    endtask

    task automatic clear_all();
        got1.delete(); exp1.delete(); got16.delete(); exp16.delete();
        fe_cnt1 = 0; ov_cnt1 = 0; fe_cnt16 = 0; ov_cnt16 = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_vec += 8;
        if (valid1 !== 1'b0) begin n_err++; $display("FAIL rst_valid1: got %b, required 0", valid1); end
        if (data1 !== 8'h00) begin n_err++; $display("FAIL rst_data1: got %h, required 00", data1); end
        if (fe1 !== 1'b0) begin n_err++; $display("FAIL rst_fe1: got %b, required 0", fe1); end
        if (ov1 !== 1'b0) begin n_err++; $display("FAIL rst_ov1: got %b, required 0", ov1); end
        if (valid16 !== 1'b0) begin n_err++; $display("FAIL rst_valid16: got %b, required 0", valid16); end
        if (data16 !== 8'h00) begin n_err++; $display("FAIL rst_data16: got %h, required 00", data16); end
        if (fe16 !== 1'b0) begin n_err++; $display("FAIL rst_fe16: got %b, required 0", fe16); end
        if (ov16 !== 1'b0) begin n_err++; $display("FAIL rst_ov16: got %b, required 0", ov16); end
        reset = 1'b0;
        repeat (4) step();
    endtask

    // Fast receiver: continuous text stream plus random bytes with short gaps.
    task automatic test_tiny_tapeout();
        string tt;
        logic [7:0] b, g;
        tt = "Tiny Tapeout ";
        clear_all();
        ready1 = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < tt.len(); i++) begin
                b = tt[i];
                exp1.push_back(b);
                send_frame(0, b, 1'b1, 0);
            end
        end
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(0, 255));
            exp1.push_back(b);
            send_frame(0, b, 1'b1, $urandom_range(0, 3));
        end
        repeat (20) step();
        n_vec++;
        if (got1.size() != exp1.size()) begin
            n_err++; $display("FAIL tiny_count: got %0d bytes, required %0d", got1.size(), exp1.size());
        end
        for (int i = 0; i < exp1.size(); i++) begin
            g = (i < got1.size()) ? got1[i] : 8'hxx;
            n_vec++;
            if (g !== exp1[i]) begin n_err++; $display("FAIL tiny_byte[%0d]: got %h, required %h", i, g, exp1[i]); end
        end
        n_vec++;
        if (fe_cnt1 != 0 || ov_cnt1 != 0) begin
            n_err++; $display("FAIL tiny_errs: frame_err=%0d overrun=%0d, required 0 0", fe_cnt1, ov_cnt1);
        end
    endtask

    // Back-to-back frames with a random ready that still pops at least every 4 cycles.
    task automatic test_back_to_back();
        logic [7:0] b, g;
        clear_all();
        rand_rdy1 = 1'b1;
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom_range(0, 255));
            exp1.push_back(b);
            send_frame(0, b, 1'b1, $urandom_range(0, 2));
        end
        repeat (20) step();
        rand_rdy1 = 1'b0;
        ready1 = 1'b1;
        repeat (4) step();
        n_vec++;
        if (got1.size() != exp1.size()) begin
            n_err++; $display("FAIL b2b_count: got %0d bytes, required %0d", got1.size(), exp1.size());
        end
        for (int i = 0; i < exp1.size(); i++) begin
            g = (i < got1.size()) ? got1[i] : 8'hxx;
            n_vec++;
            if (g !== exp1[i]) begin n_err++; $display("FAIL b2b_byte[%0d]: got %h, required %h", i, g, exp1[i]); end
        end
        n_vec++;
        if (ov_cnt1 != 0) begin n_err++; $display("FAIL b2b_overrun: got %0d, required 0", ov_cnt1); end
    endtask

    // Slow receiver: a known frame, a short glitch, then random frames.
    task automatic test_slow_and_glitch();
        logic [7:0] b, g;
        clear_all();
        ready16 = 1'b1;
        exp16.push_back(8'hA5);
        send_frame(1, 8'hA5, 1'b1, 2);
        repeat (10) step();
        drive_line(1, 1'b0, 4);
        drive_line(1, 1'b1, 48);
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            exp16.push_back(b);
            send_frame(1, b, 1'b1, $urandom_range(0, 2));
        end
        repeat (40) step();
        n_vec++;
        if (got16.size() != exp16.size()) begin
            n_err++; $display("FAIL slow_count: got %0d bytes, required %0d", got16.size(), exp16.size());
        end
        for (int i = 0; i < exp16.size(); i++) begin
            g = (i < got16.size()) ? got16[i] : 8'hxx;
            n_vec++;
            if (g !== exp16[i]) begin n_err++; $display("FAIL slow_byte[%0d]: got %h, required %h", i, g, exp16[i]); end
        end
        n_vec++;
        if (fe_cnt16 != 0 || ov_cnt16 != 0) begin
            n_err++; $display("FAIL slow_errs: frame_err=%0d overrun=%0d, required 0 0", fe_cnt16, ov_cnt16);
        end
    endtask

    // Bad stop bits: long break on the slow receiver, random bad frames on the fast one.
    task automatic test_frame_err();
        logic [7:0] b, g;
        int bad;
        clear_all();
        send_frame(1, 8'h3C, 1'b0, 0);
        drive_line(1, 1'b0, 40 * 16);
        drive_line(1, 1'b1, 2 * 16);
        exp16.push_back(8'h81);
        send_frame(1, 8'h81, 1'b1, 2);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) begin
                bad++;
                send_frame(0, b, 1'b0, 0);
                drive_line(0, 1'b0, $urandom_range(0, 12));
                drive_line(0, 1'b1, 1);
            end else begin
                exp1.push_back(b);
                send_frame(0, b, 1'b1, $urandom_range(0, 2));
            end
        end
        repeat (20) step();
        n_vec += 4;
        if (fe_cnt16 != 1) begin n_err++; $display("FAIL ferr_pulses16: got %0d, required 1", fe_cnt16); end
        g = (got16.size() > 0) ? got16[0] : 8'hxx;
        if (got16.size() != 1 || g !== 8'h81) begin
            n_err++; $display("FAIL ferr_next16: got %0d bytes first %h, required 1 byte 81", got16.size(), g);
        end
        if (fe_cnt1 != bad) begin n_err++; $display("FAIL ferr_pulses1: got %0d, required %0d", fe_cnt1, bad); end
        if (got1.size() != exp1.size()) begin
            n_err++; $display("FAIL ferr_count1: got %0d bytes, required %0d", got1.size(), exp1.size());
        end
        for (int i = 0; i < exp1.size(); i++) begin
            g = (i < got1.size()) ? got1[i] : 8'hxx;
            n_vec++;
            if (g !== exp1[i]) begin n_err++; $display("FAIL ferr_byte1[%0d]: got %h, required %h", i, g, exp1[i]); end
        end
    endtask

    // Fill the buffer with ready low; extra bytes must be dropped with an overrun pulse.
    task automatic test_overrun();
        logic [7:0] list[$];
        logic [7:0] g;
        for (int round = 0; round < 2; round++) begin
            clear_all();
            list.delete();
            if (round == 0) begin
`ifdef UART_RX_FIFO_EN
                for (int i = 1; i <= 5; i++) list.push_back(8'(i));
`else
                list.push_back(8'h11);
                list.push_back(8'h22);
`endif
            end else begin
                for (int i = 0; i < DEPTH + $urandom_range(0, 2); i++) list.push_back(8'($urandom_range(0, 255)));
            end
            ready1 = 1'b0;
            foreach (list[i]) send_frame(0, list[i], 1'b1, 1);
            repeat (8) step();
            n_vec += 3;
            if (ov_cnt1 != list.size() - DEPTH) begin
                n_err++; $display("FAIL ovr_pulses: got %0d, required %0d", ov_cnt1, list.size() - DEPTH);
            end
            if (valid1 !== 1'b1 || data1 !== list[0]) begin
                n_err++; $display("FAIL ovr_head: valid=%b data=%h, required valid=1 data=%h", valid1, data1, list[0]);
            end
            if (got1.size() != 0) begin n_err++; $display("FAIL ovr_early: got %0d pops, required 0", got1.size()); end
            ready1 = 1'b1;
            repeat (8) step();
            n_vec++;
            if (got1.size() != DEPTH) begin
                n_err++; $display("FAIL ovr_drain: got %0d bytes, required %0d", got1.size(), DEPTH);
            end
            for (int i = 0; i < DEPTH; i++) begin
                g = (i < got1.size()) ? got1[i] : 8'hxx;
                n_vec++;
                if (g !== list[i]) begin n_err++; $display("FAIL ovr_byte[%0d]: got %h, required %h", i, g, list[i]); end
            end
        end
    endtask

    // Reset in the middle of a slow frame abandons it silently.
    task automatic test_reset_mid();
        logic [7:0] g;
        clear_all();
        ready16 = 1'b1;
        drive_line(1, 1'b0, 16);
        drive_line(1, 1'b1, 4 * 16 + 4);
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        n_vec += 2;
        if (valid16 !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b, required 0", valid16); end
        if (fe16 !== 1'b0) begin n_err++; $display("FAIL rmid_fe: got %b, required 0", fe16); end
        drive_line(1, 1'b1, 5 * 16);
        send_frame(1, 8'h5A, 1'b1, 2);
        repeat (10) step();
        n_vec += 2;
        g = (got16.size() > 0) ? got16[0] : 8'hxx;
        if (got16.size() != 1 || g !== 8'h5A) begin
            n_err++; $display("FAIL rmid_next: got %0d bytes first %h, required 1 byte 5a", got16.size(), g);
        end
        if (fe_cnt16 != 0) begin n_err++; $display("FAIL rmid_ferr: got %0d, required 0", fe_cnt16); end
    endtask

    initial begin
        test_reset();
        test_tiny_tapeout();
        test_back_to_back();
        test_slow_and_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1, clk cycles per serial bit (legal >= 1).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rx_pin  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port rx_data  output  8  received byte at head of output buffer.
REQ-006 SHALL have port rx_valid  output  1  rx_data holds an unread byte.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts rx_data this cycle.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: good byte dropped, buffer full.

Function
REQ-010 SHALL pass rx_pin through a 2-flop synchronizer (rx_s), reset value 1; all decoding uses rx_s only.
REQ-011 SHALL use HALF = (CLKS_PER_BIT-1)/2 (integer division) and a bit-period down-counter sized for CLKS_PER_BIT-1.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-013 IDLE: rx_s==0 and HALF==0 -> DATA, counter=CLKS_PER_BIT-1, bit index 0; rx_s==0 and HALF>0 -> START, counter=HALF-1.
REQ-014 START: at counter==0 re-sample rx_s; 0 -> DATA (counter=CLKS_PER_BIT-1); 1 -> IDLE (glitch, no output, no error).
REQ-015 DATA: at counter==0 shift rx_s into bit[index], index 0..7 LSB first, reload counter; after bit 7 -> STOP.
REQ-016 STOP: at counter==0 sample rx_s; 1 -> push byte, IDLE; 0 -> frame_err pulse, discard byte, WAIT_IDLE.
REQ-017 WAIT_IDLE: remain until rx_s==1, then IDLE (line break never retriggers reception).
REQ-018 Push SHALL occur in the cycle after the stop-bit sample; byte visible at rx_valid/rx_data next cycle when buffer was empty.
REQ-019 Handshake: pop when rx_valid && rx_ready; rx_data stable while rx_valid && !rx_ready.
REQ-020 Push when full and no pop same cycle SHALL drop the new byte and pulse overrun; buffered bytes unchanged.
REQ-021 Push and pop same cycle when full SHALL succeed with no overrun; when empty, rx_valid stays asserted with new byte.
REQ-022 CLKS_PER_BIT==1 SHALL decode back-to-back frames with any idle gap >= 0 bits.

Reset
REQ-023 Reset SHALL force: state IDLE, counters 0, synchronizer 1, buffer empty, rx_valid 0, rx_data 0, frame_err 0, overrun 0.
REQ-024 Reset mid-frame SHALL abandon the frame with no push, no error pulse; reception restarts at next falling edge after reset releases.

Configuration
REQ-025 Macro UART_RX_FIFO_EN defined: output buffer SHALL be a 4-entry FIFO, first in first out.
REQ-026 Macro UART_RX_FIFO_EN undefined: output buffer SHALL be a single holding register (depth 1); all handshake/overrun rules unchanged.

Structure
REQ-027 Package uart_pkg SHALL hold the receiver state enum, UART_DATA_W=8 and UART_FIFO_DEPTH=4.
REQ-028 Buffer SHALL be sub-module uart_rx_fifo (push/pop/full/empty, depth parameter), instantiated with depth 4 or 1 per macro.

Verification
REQ-029 CLKS_PER_BIT=1, rx_ready=1, rx_pin driven by 1-clk/bit transmitter repeating "Tiny Tapeout " (idle,start,8 data,stop) -> bytes 0x54,0x69,0x6E,0x79,0x20,... in order, no errors.
REQ-030 CLKS_PER_BIT=16, frame 0xA5 -> rx_data=0xA5, one rx_valid; 4-cycle low glitch on idle line -> no output, no error.
REQ-031 Frame 0x3C with stop bit low, line then held low 40 bits -> exactly one frame_err pulse, no push, next frame 0x81 after line returns high -> 0x81.
REQ-032 FIFO_EN, rx_ready=0, send 0x01..0x05 -> four held (0x01..0x04), overrun pulses once on 0x05; then rx_ready=1 -> 0x01,0x02,0x03,0x04.
REQ-033 FIFO_EN off, rx_ready=0, send 0x11,0x22 -> rx_data holds 0x11, overrun on 0x22.
REQ-034 Reset asserted during DATA bit 4 of 0xFF -> no rx_valid, no frame_err; following frame 0x5A received correctly.
